// File: rtl/regfile_dump_if.sv
// Beat stream carrying register-file dump words from regfile_dump to the debug/trace path.
interface regfile_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_idx;
    logic [31:0] out_data;
    logic        out_last;

    modport master (output out_valid, out_idx, out_data, out_last, input out_ready);
    modport slave  (input out_valid, out_idx, out_data, out_last, output out_ready);
endinterface

// File: rtl/regfile_dump.sv
// Walks the register file read port x0..x(NUM_REGS-1) and streams each word as an indexed beat.
// Optional trailing XOR checksum beat (idx 32) when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned ADDR_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [31:0]       rf_data,
    regfile_dump_if.master    beat,
    output logic              busy,
    output logic              halt_req,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
`ifdef REGDUMP_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } state_t;

    state_t state, state_nxt;
    logic   hs;

`ifdef REGDUMP_CHECKSUM_EN
    logic [31:0] csum;
`endif

    assign hs = beat.out_valid && beat.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = READ;
            READ: state_nxt = SEND;
            SEND: begin
                if (hs) begin
                    if (rf_addr != LAST_ADDR) state_nxt = READ;
`ifdef REGDUMP_CHECKSUM_EN
                    else                      state_nxt = CSUM;
`else
                    else                      state_nxt = DONE;
`endif
                end
            end
`ifdef REGDUMP_CHECKSUM_EN
            CSUM: if (hs) state_nxt = DONE;
`endif
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // abort overrides everything outside IDLE; a coinciding handshake still completes
        if (abort && state != IDLE) state_nxt = IDLE;
    end

    always_comb begin
        busy     = (state != IDLE);
        halt_req = (state != IDLE);
        done     = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_addr        <= '0;
            beat.out_valid <= 1'b0;
            beat.out_idx   <= '0;
            beat.out_data  <= '0;
            beat.out_last  <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            csum           <= '0;
`endif
        end else if (abort && state != IDLE) begin
            beat.out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rf_addr <= '0;
`ifdef REGDUMP_CHECKSUM_EN
                        csum    <= '0;
`endif
                    end
                end
                READ: begin
                    beat.out_valid <= 1'b1;
                    beat.out_data  <= rf_data;
                    beat.out_idx   <= 6'(rf_addr);
`ifdef REGDUMP_CHECKSUM_EN
                    csum           <= csum ^ rf_data;
                    beat.out_last  <= 1'b0;
`else
                    beat.out_last  <= (rf_addr == LAST_ADDR);
`endif
                end
                SEND: begin
                    if (hs) begin
                        if (rf_addr != LAST_ADDR) begin
                            rf_addr        <= rf_addr + ADDR_W'(1);
                            beat.out_valid <= 1'b0;
                        end else begin
`ifdef REGDUMP_CHECKSUM_EN
                            // checksum beat is loaded straight from SEND so it follows with no READ gap
                            beat.out_valid <= 1'b1;
                            beat.out_idx   <= 6'd32;
                            beat.out_data  <= csum;
                            beat.out_last  <= 1'b1;
`else
                            beat.out_valid <= 1'b0;
`endif
                        end
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                CSUM: if (hs) beat.out_valid <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump.sv
// Directed bench for regfile_dump with a beat-queue reference model checked every cycle.
module tb_regfile_dump;

    localparam int NUM = 32;
`ifdef REGDUMP_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int NBEATS = NUM + CS;

    logic        clk = 1'b0;
    logic        rst_n, start, abort;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        busy, halt_req, done;
    logic [31:0] rf [NUM];

    regfile_dump_if bus ();

    regfile_dump #(.NUM_REGS(NUM), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .rf_addr  (rf_addr),
        .rf_data  (rf_data),
        .beat     (bus),
        .busy     (busy),
        .halt_req (halt_req),
        .done     (done)
    );

    assign rf_data = rf[rf_addr];

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // reference model: the dump is a queue of expected beats built when start is accepted
    typedef struct { int idx; logic [31:0] dat; } beat_t;
    beat_t       q[$];
    bit          m_busy, m_done_due, m_gap;
    int          ncyc, start_ncyc, hs_n, done_cnt, busy_cnt, stall7;
    int          hs_idx [64];
    logic [31:0] hs_dat [64];
    int          hs_cyc [64];
    logic [31:0] m_xor;

    initial begin
        bit hs, nd, ng, exp_valid;
        m_busy = 0; m_done_due = 0; m_gap = 0;
        ncyc = 0; start_ncyc = 0; hs_n = 0; done_cnt = 0; busy_cnt = 0; stall7 = 0;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!rst_n) begin
                chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                m_busy = 0; m_done_due = 0; m_gap = 0;
                q.delete();
                continue;
            end
            exp_valid = m_busy && (q.size() > 0) && !m_gap;
            chk("busy", 32'(busy), 32'(m_busy));
            chk("halt_req", 32'(halt_req), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done_due));
            chk("out_valid", 32'(bus.out_valid), 32'(exp_valid));
            if (exp_valid && bus.out_valid) begin
                chk("out_idx", 32'(bus.out_idx), 32'(q[0].idx));
                chk("out_data", bus.out_data, q[0].dat);
                chk("out_last", 32'(bus.out_last), 32'(q.size() == 1));
            end
            if (m_busy && q.size() > 0 && q[0].idx < NUM)
                chk("rf_addr", 32'(rf_addr), 32'(q[0].idx));

            hs = bus.out_valid && bus.out_ready;
            if (m_busy && hs && q.size() > 0 && hs_n < 64) begin
                hs_idx[hs_n] = int'(bus.out_idx);
                hs_dat[hs_n] = bus.out_data;
                hs_cyc[hs_n] = ncyc;
                hs_n++;
            end
            if (bus.out_valid && !bus.out_ready && int'(bus.out_idx) == 7) stall7++;
            if (busy) busy_cnt++;
            if (done) done_cnt++;

            if (!m_busy) begin
                m_gap = 0;
                if (start) begin
                    q.delete();
                    m_xor = '0;
                    for (int i = 0; i < NUM; i++) begin
                        q.push_back('{idx: i, dat: rf[i]});
                        m_xor ^= rf[i];
                    end
`ifdef REGDUMP_CHECKSUM_EN
                    q.push_back('{idx: 32, dat: m_xor});
`endif
                    m_busy = 1; m_gap = 1; m_done_due = 0;
                    hs_n = 0; done_cnt = 0; busy_cnt = 0; stall7 = 0;
                    start_ncyc = ncyc;
                end
            end else begin
                nd = 0; ng = 0;
                if (hs && q.size() > 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0)       nd = 1;
                    else if (q[0].idx < NUM) ng = 1;
                end
                if (m_done_due || abort) begin
                    m_busy = 0; nd = 0; ng = 0;
                    q.delete();
                end
                m_done_due = nd;
                m_gap      = ng;
            end
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_out_idx"},   32'(bus.out_idx),   32'd0);
        chk({tag, "_out_data"},  bus.out_data,       32'd0);
        chk({tag, "_out_last"},  32'(bus.out_last),  32'd0);
        chk({tag, "_busy"},      32'(busy),          32'd0);
        chk({tag, "_halt_req"},  32'(halt_req),      32'd0);
        chk({tag, "_done"},      32'(done),          32'd0);
        chk({tag, "_rf_addr"},   32'(rf_addr),       32'd0);
    endtask

    // drives one dump; negative indices disable stall / duplicate start / abort / reset events
    task automatic run_dump(input int stall_idx, input int stall_len, input int dup_idx,
                            input int abort_idx, input int rst_idx);
        int scnt;
        bit dup_done, aborted, fin;
        int c;
        scnt = 0; dup_done = 0; aborted = 0; fin = 0; c = 0;
        start = 1'b1;
        while (!fin && c < 400) begin
            @(posedge clk); #1;
            c++;
            start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
            if (aborted) begin
                chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
                chk("abort_busy", 32'(busy), 32'd0);
                chk("abort_done", 32'(done), 32'd0);
                fin = 1;
            end else if (done) begin
                fin = 1;
            end else if (bus.out_valid) begin
                if (int'(bus.out_idx) == rst_idx) begin
                    rst_n = 1'b0;
                    #1;
                    reset_checks("midrst");
                    repeat (2) @(posedge clk);
                    #1;
                    rst_n = 1'b1;
                    fin = 1;
                end else if (int'(bus.out_idx) == abort_idx) begin
                    bus.out_ready = 1'b0;
                    abort = 1'b1;
                    aborted = 1;
                end else if (int'(bus.out_idx) == stall_idx && scnt < stall_len) begin
                    bus.out_ready = 1'b0;
                    scnt++;
                end else if (int'(bus.out_idx) == dup_idx && !dup_done) begin
                    start = 1'b1;
                    dup_done = 1;
                end
            end
        end
        chk("dump_terminated", 32'(fin), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n7;
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
        for (int i = 0; i < NUM; i++) rf[i] = 32'(i) * 32'h01010101;
        #2 rst_n = 1'b0;
        idle(3);
        reset_checks("reset");
        rst_n = 1'b1;
        idle(1);

        // basic dump with out_ready held high
        run_dump(-1, 0, -1, -1, -1);
        idle(3);
        chk("basic_beats", 32'(hs_n), 32'(NBEATS));
        chk("basic_idx0", 32'(hs_idx[0]), 32'd0);
        chk("basic_idx31", 32'(hs_idx[31]), 32'd31);
        chk("basic_x0", hs_dat[0], 32'h00000000);
        chk("basic_x7", hs_dat[7], 32'h07070707);
        chk("basic_x31", hs_dat[31], 32'h1F1F1F1F);
        chk("basic_first_latency", 32'(hs_cyc[0] - start_ncyc), 32'd2);
        chk("basic_beat_span", 32'(hs_cyc[31] - hs_cyc[0]), 32'd62);
        chk("basic_done_count", 32'(done_cnt), 32'd1);
        chk("basic_busy_span", 32'(busy_cnt), 32'(2 * NUM + CS + 1));
`ifdef REGDUMP_CHECKSUM_EN
        chk("basic_csum_idx", 32'(hs_idx[32]), 32'd32);
        chk("basic_csum_data", hs_dat[32], 32'h00000000);
`endif

        // backpressure on beat 7
        run_dump(7, 5, -1, -1, -1);
        idle(3);
        n7 = 0;
        for (int i = 0; i < hs_n; i++) if (hs_idx[i] == 7) n7++;
        chk("bp_stall_cycles", 32'(stall7), 32'd5);
        chk("bp_beat7_once", 32'(n7), 32'd1);
        chk("bp_beats", 32'(hs_n), 32'(NBEATS));
        chk("bp_gap7", 32'(hs_cyc[7] - hs_cyc[6]), 32'd7);
        chk("bp_gap8", 32'(hs_cyc[8] - hs_cyc[7]), 32'd2);
        chk("bp_x7", hs_dat[7], 32'h07070707);

        // start pulse while busy at beat 10
        run_dump(-1, 0, 10, -1, -1);
        idle(10);
        chk("dup_beats", 32'(hs_n), 32'(NBEATS));
        chk("dup_done_count", 32'(done_cnt), 32'd1);
        chk("dup_busy_span", 32'(busy_cnt), 32'(2 * NUM + CS + 1));
        chk("dup_idle_busy", 32'(busy), 32'd0);

        // abort during SEND of beat 12, then restart
        run_dump(-1, 0, -1, 12, -1);
        idle(3);
        chk("abort_beats", 32'(hs_n), 32'd12);
        chk("abort_done_count", 32'(done_cnt), 32'd0);
        run_dump(-1, 0, -1, -1, -1);
        idle(3);
        chk("restart_idx0", 32'(hs_idx[0]), 32'd0);
        chk("restart_beats", 32'(hs_n), 32'(NBEATS));
        chk("restart_done_count", 32'(done_cnt), 32'd1);

        // reset at beat 20 with fresh contents, then a clean dump
        for (int i = 0; i < NUM; i++) rf[i] = $urandom();
        run_dump(-1, 0, -1, -1, 20);
        idle(2);
        run_dump(-1, 0, -1, -1, -1);
        idle(3);
        chk("postrst_beats", 32'(hs_n), 32'(NBEATS));
        chk("postrst_done_count", 32'(done_cnt), 32'd1);
        chk("postrst_x5", hs_dat[5], rf[5]);
        chk("postrst_x31", hs_dat[31], rf[31]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
